// File: rtl/cargador_pkg.sv
// Shared definitions for the instruction-memory byte loader.
// State encoding and word geometry used by the top level and the serializer.
package cargador_pkg;

   localparam int ANCHO_PALABRA     = 32;
   localparam int BYTES_POR_PALABRA = 4;

   typedef enum logic [1:0] {
      INACTIVO = 2'd0,
      ESPERA   = 2'd1,
      ESCRIBE  = 2'd2
   } estado_t;

endpackage

// File: rtl/cargador_instrucciones_if.sv
// Word handshake between the program-load source and the loader.
// The source drives the word and its valid flag; the loader answers with lista.
interface cargador_instrucciones_if;
   import cargador_pkg::*;

   logic [ANCHO_PALABRA-1:0] palabra;
   logic                     palabra_valida;
   logic                     palabra_lista;

   modport master (output palabra, output palabra_valida, input palabra_lista);
   modport slave  (input palabra, input palabra_valida, output palabra_lista);

endinterface

// File: rtl/serializador_palabra.sv
// Holds one accepted instruction word and walks it out byte by byte,
// most significant byte first, flagging the final byte.
module serializador_palabra
   import cargador_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cargar,
   input  logic                     avanzar,
   input  logic [ANCHO_PALABRA-1:0] palabra,
   output logic [1:0]               k,
   output logic [7:0]               byte_k,
   output logic                     ultimo
);

   logic [ANCHO_PALABRA-1:0] palabra_r;
   logic [1:0]               k_r;
   logic [7:0]               byte_s;

   // Word latch and byte index; loading restarts the index at the top byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         palabra_r <= 32'h0000_0000;
         k_r       <= 2'd0;
      end else if (cargar) begin
         palabra_r <= palabra;
         k_r       <= 2'd0;
      end else if (avanzar) begin
         k_r       <= k_r + 2'd1;
      end else begin
         k_r       <= k_r;
      end
   end

   // Big-endian byte select.
   always_comb begin
      byte_s = 8'h00;
      case (k_r)
         2'd0:    byte_s = palabra_r[31:24];
         2'd1:    byte_s = palabra_r[23:16];
         2'd2:    byte_s = palabra_r[15:8];
         2'd3:    byte_s = palabra_r[7:0];
         default: byte_s = 8'h00;
      endcase
   end

   assign k      = k_r;
   assign byte_k = byte_s;
   assign ultimo = (k_r == 2'(BYTES_POR_PALABRA - 1));

endmodule

// File: rtl/cargador_instrucciones.sv
// Writer side of the instruction memory: takes 32-bit words over a handshake
// and writes each as four big-endian bytes at consecutive byte addresses.
module cargador_instrucciones
   import cargador_pkg::*;
#(
   parameter int ANCHO_DIR = 8
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inicio,
   input  logic [ANCHO_DIR-1:0]   dir_base,
   cargador_instrucciones_if.slave bus,
   input  logic                   fin,
   output logic                   mem_we,
   output logic [ANCHO_DIR-1:0]   mem_dir,
   output logic [7:0]             mem_dato,
   output logic                   ocupado,
   output logic [ANCHO_DIR-2:0]   cuenta_palabras,
   output logic                   lleno
);

   // Byte address of the last word slot; writing it ends the session.
   localparam logic [ANCHO_DIR-1:0] PTR_ULTIMO = {{(ANCHO_DIR-2){1'b1}}, 2'b00};

   estado_t              estado_r;
   estado_t              estado_s;
   logic [ANCHO_DIR-1:0] ptr_r;
   logic [ANCHO_DIR-2:0] cuenta_r;
   logic                 lleno_r;
   logic                 fin_pend_r;

   logic                 transfer_s;
   logic                 escribe_s;
   logic                 ultimo_s;
   logic [1:0]           k_s;
   logic [7:0]           byte_s;

   assign transfer_s = (estado_r == ESPERA) && bus.palabra_valida;
   assign escribe_s  = (estado_r == ESCRIBE);

   serializador_palabra u_serializador (
      .clk     (clk),
      .rst     (rst),
      .cargar  (transfer_s),
      .avanzar (escribe_s),
      .palabra (bus.palabra),
      .k       (k_s),
      .byte_k  (byte_s),
      .ultimo  (ultimo_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_r <= INACTIVO;
      end else begin
         estado_r <= estado_s;
      end
   end

   // Next-state decode; a fin seen on the last byte still closes the session.
   always_comb begin
      estado_s = estado_r;
      case (estado_r)
         INACTIVO: begin
            if (inicio) estado_s = ESPERA;
            else        estado_s = INACTIVO;
         end
         ESPERA: begin
            if (transfer_s) estado_s = ESCRIBE;
            else if (fin)   estado_s = INACTIVO;
            else            estado_s = ESPERA;
         end
         ESCRIBE: begin
            if (!ultimo_s)                  estado_s = ESCRIBE;
            else if (ptr_r == PTR_ULTIMO)   estado_s = INACTIVO;
            else if (fin_pend_r || fin)     estado_s = INACTIVO;
            else                            estado_s = ESPERA;
         end
         default: estado_s = INACTIVO;
      endcase
   end

   // Session pointer, word count and sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r      <= '0;
         cuenta_r   <= '0;
         lleno_r    <= 1'b0;
         fin_pend_r <= 1'b0;
      end else begin
         case (estado_r)
            INACTIVO: begin
               if (inicio) begin
                  ptr_r      <= dir_base & ~ANCHO_DIR'(3);
                  cuenta_r   <= '0;
                  lleno_r    <= 1'b0;
                  fin_pend_r <= 1'b0;
               end
            end
            ESPERA: begin
               if (transfer_s && fin) fin_pend_r <= 1'b1;
            end
            ESCRIBE: begin
               if (fin) fin_pend_r <= 1'b1;
               if (ultimo_s) begin
                  cuenta_r <= cuenta_r + 1'b1;
                  ptr_r    <= ptr_r + ANCHO_DIR'(BYTES_POR_PALABRA);
                  if (ptr_r == PTR_ULTIMO) lleno_r <= 1'b1;
               end
            end
            default: begin
               ptr_r <= ptr_r;
            end
         endcase
      end
   end

   assign bus.palabra_lista = (estado_r == ESPERA);
   assign ocupado           = (estado_r != INACTIVO);
   assign mem_we            = escribe_s;
   assign mem_dir           = escribe_s ? (ptr_r + ANCHO_DIR'(k_s)) : '0;
   assign mem_dato          = escribe_s ? byte_s : 8'h00;
   assign cuenta_palabras   = cuenta_r;
   assign lleno             = lleno_r;

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Bench for the instruction-memory loader: directed sessions plus random
// words, scored against a byte-address memory model of big-endian writes.
module tb_cargador_instrucciones;

   logic       clk = 1'b0;
   logic       rst;
   logic       inicio;
   logic       fin;
   logic [7:0] dir_base;
   logic       mem_we;
   logic [7:0] mem_dir;
   logic [7:0] mem_dato;
   logic       ocupado;
   logic [6:0] cuenta_palabras;
   logic       lleno;

   cargador_instrucciones_if bus_if ();

   cargador_instrucciones #(.ANCHO_DIR(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .inicio          (inicio),
      .dir_base        (dir_base),
      .bus             (bus_if.slave),
      .fin             (fin),
      .mem_we          (mem_we),
      .mem_dir         (mem_dir),
      .mem_dato        (mem_dato),
      .ocupado         (ocupado),
      .cuenta_palabras (cuenta_palabras),
      .lleno           (lleno)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_x = 0;
   logic [7:0] mem_obs [256];
   bit         wrflag [256];
   logic [15:0] exp_q [$];
   logic [7:0] m_ptr;
   int         m_cnt;
   logic       m_lleno;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: outputs sampled just before the edge are what the memory and
   // the handshake act on at that edge.
   task automatic tick();
      logic        we, x;
      logic [7:0]  d, b, a, v;
      logic [31:0] w;
      logic [15:0] e;
      we = mem_we; d = mem_dir; b = mem_dato;
      x  = bus_if.palabra_lista && bus_if.palabra_valida;
      w  = bus_if.palabra;
      @(posedge clk);
      #1;
      cyc++;
      if (x) begin
         last_x = cyc;
         for (int i = 0; i < 4; i++) begin
            a = m_ptr + 8'(i);
            v = 8'((w >> (24 - 8 * i)) & 32'hFF);
            exp_q.push_back({a, v});
         end
         m_ptr = m_ptr + 8'd4;
         m_cnt++;
         if (m_ptr == 8'd0) m_lleno = 1'b1;
      end
      if (we) begin
         wrflag[d]  = 1'b1;
         mem_obs[d] = b;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL spurious_write observed dir=%h dato=%h expected no write", d, b);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("write_dir_dato", {16'h0, d, b}, {16'h0, e});
         end
      end
   endtask

   task automatic start_session(input logic [7:0] base);
      inicio = 1'b1; dir_base = base;
      m_ptr = base & 8'hFC; m_cnt = 0; m_lleno = 1'b0;
      tick();
      inicio = 1'b0; dir_base = 8'h00;
      check("lista_after_inicio", {31'h0, bus_if.palabra_lista}, 32'h1);
   endtask

   task automatic wait_lista();
      for (int n = 0; n < 20 && !bus_if.palabra_lista; n++) tick();
      check("lista_wait", {31'h0, bus_if.palabra_lista}, 32'h1);
   endtask

   task automatic send_word(input logic [31:0] w, input logic f);
      wait_lista();
      bus_if.palabra = w; bus_if.palabra_valida = 1'b1; fin = f;
      tick();
      bus_if.palabra_valida = 1'b0; fin = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("lista_we_during_write", {30'h0, bus_if.palabra_lista, mem_we}, 32'h1);
         tick();
      end
   endtask

   task automatic clear_flags();
      for (int i = 0; i < 256; i++) wrflag[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  base;
      logic [31:0] w;
      int          first_x, n;

      rst = 1'b1; inicio = 1'b0; fin = 1'b0; dir_base = 8'h00;
      bus_if.palabra = 32'h0; bus_if.palabra_valida = 1'b0;
      m_ptr = 8'h00; m_cnt = 0; m_lleno = 1'b0;
      for (int i = 0; i < 256; i++) mem_obs[i] = 8'h00;
      clear_flags();
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs",
            {9'h0, bus_if.palabra_lista, mem_we, mem_dir, mem_dato, ocupado, cuenta_palabras, lleno},
            32'h0);
      rst = 1'b0;
      tick();

      // Aligned load.
      start_session(8'h00);
      send_word(32'h014A1820, 1'b0);
      check("aligned_count", {25'h0, cuenta_palabras}, 32'd1);
      check("aligned_lista", {31'h0, bus_if.palabra_lista}, 32'h1);
      check("aligned_mem", {mem_obs[0], mem_obs[1], mem_obs[2], mem_obs[3]}, 32'h014A1820);
      fin = 1'b1; tick(); fin = 1'b0;
      check("aligned_end_idle", {31'h0, ocupado}, 32'h0);

      // Unaligned base, back-to-back words.
      start_session(8'h07);
      wait_lista();
      bus_if.palabra = 32'h11223344; bus_if.palabra_valida = 1'b1;
      tick();
      first_x = last_x;
      bus_if.palabra = 32'hAABBCCDD;
      repeat (4) tick();
      check("b2b_lista_again", {31'h0, bus_if.palabra_lista}, 32'h1);
      tick();
      bus_if.palabra_valida = 1'b0;
      check("b2b_spacing", 32'(last_x - first_x), 32'd5);
      repeat (4) tick();
      check("b2b_count", {25'h0, cuenta_palabras}, 32'd2);
      check("b2b_mem_lo", {mem_obs[4], mem_obs[5], mem_obs[6], mem_obs[7]}, 32'h11223344);
      check("b2b_mem_hi", {mem_obs[8], mem_obs[9], mem_obs[10], mem_obs[11]}, 32'hAABBCCDD);
      fin = 1'b1; tick(); fin = 1'b0;

      // Fill boundary.
      clear_flags();
      start_session(8'hFC);
      send_word(32'hDEADBEEF, 1'b0);
      check("fill_lleno", {31'h0, lleno}, 32'h1);
      check("fill_ocupado", {31'h0, ocupado}, 32'h0);
      check("fill_count", {25'h0, cuenta_palabras}, 32'd1);
      check("fill_mem", {mem_obs[252], mem_obs[253], mem_obs[254], mem_obs[255]}, 32'hDEADBEEF);
      bus_if.palabra = $urandom; bus_if.palabra_valida = 1'b1;
      repeat (6) tick();
      bus_if.palabra_valida = 1'b0;
      check("fill_no_write_0", {31'h0, wrflag[0]}, 32'h0);
      check("fill_lleno_holds", {31'h0, lleno}, 32'h1);

      // fin together with the transfer.
      base = 8'($urandom_range(8, 39) * 4);
      start_session(base);
      send_word(32'h00000013, 1'b1);
      check("simfin_ocupado", {31'h0, ocupado}, 32'h0);
      check("simfin_count", {25'h0, cuenta_palabras}, 32'd1);
      check("simfin_lleno", {31'h0, lleno}, 32'h0);
      check("simfin_mem", {mem_obs[base], mem_obs[base+8'd1], mem_obs[base+8'd2], mem_obs[base+8'd3]},
            32'h00000013);

      // fin with no word pending.
      start_session(8'h30);
      fin = 1'b1; tick(); fin = 1'b0;
      check("fin_idle", {30'h0, ocupado, bus_if.palabra_lista}, 32'h0);
      repeat (3) tick();

      // inicio while writing leaves the pointer alone.
      clear_flags();
      start_session(8'h40);
      wait_lista();
      bus_if.palabra = $urandom; bus_if.palabra_valida = 1'b1;
      tick();
      bus_if.palabra_valida = 1'b0;
      inicio = 1'b1; dir_base = 8'h80;
      tick();
      inicio = 1'b0; dir_base = 8'h00;
      repeat (3) tick();
      send_word($urandom, 1'b1);
      check("busy_inicio_count", {25'h0, cuenta_palabras}, 32'd2);
      check("busy_inicio_no_80", {31'h0, wrflag[8'h80]}, 32'h0);
      check("busy_inicio_44", {31'h0, wrflag[8'h44]}, 32'h1);

      // Random session with random gaps.
      base = 8'($urandom_range(0, 48) * 4 + $urandom_range(0, 3));
      start_session(base);
      n = $urandom_range(3, 6);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         w = $urandom;
         send_word(w, (i == n - 1) ? 1'b1 : 1'b0);
      end
      check("rand_count", {25'h0, cuenta_palabras}, 32'(m_cnt));
      check("rand_ocupado", {31'h0, ocupado}, 32'h0);
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a word.
      clear_flags();
      start_session(8'h10);
      wait_lista();
      bus_if.palabra = 32'hCAFEBABE; bus_if.palabra_valida = 1'b1;
      tick();
      bus_if.palabra_valida = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      check("rst_async_outputs",
            {9'h0, bus_if.palabra_lista, mem_we, mem_dir, mem_dato, ocupado, cuenta_palabras, lleno},
            32'h0);
      check("rst_pending_bytes", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();
      check("rst_written", {16'h0, mem_obs[8'h10], mem_obs[8'h11]}, 32'h0000CAFE);
      check("rst_not_written", {30'h0, wrflag[8'h12], wrflag[8'h13]}, 32'h0);
      check("rst_idle", {31'h0, ocupado}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
